// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destination tags from EX to the last
// forwardable stage, drives per-source ALU operand selects and a load-use stall request for ID.
module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     id_valid_i,
    input  logic [NUM_SRC*AW-1:0]    id_src_i,
    input  logic [NUM_SRC-1:0]       id_src_use_i,
    input  logic [AW-1:0]            id_dst_i,
    input  logic                     id_we_i,
    input  logic                     id_load_i,
    input  logic                     flush_i,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic                     stall_o,
    output logic [15:0]              stall_cnt_o
);

    if (LOAD_STAGE < 1 || LOAD_STAGE > FWD_STAGES) begin : g_param_check
        $error("fwd_hazard_unit: LOAD_STAGE must satisfy 1 <= LOAD_STAGE <= FWD_STAGES");
    end

    // Tag pipeline, index 0 = EX, index FWD_STAGES = oldest forwardable producer.
    logic [FWD_STAGES:0]              v_q, we_q, ld_q;
    logic [FWD_STAGES:0][AW-1:0]      dst_q;
    logic [NUM_SRC-1:0][AW-1:0]       ex_src_q;
    logic [NUM_SRC-1:0]               ex_use_q;
    logic [15:0]                      stall_cnt_q;
    logic [NUM_SRC-1:0]               load_hit;
    logic                             issue;

    assign issue = id_valid_i & ~flush_i & ~stall_o;

    // NOTE: state is only ever updated with <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v_q         <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            dst_q       <= '0;
            ex_src_q    <= '0;
            ex_use_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q      <= {v_q[FWD_STAGES-1:0], issue};
            we_q     <= {we_q[FWD_STAGES-1:0], id_we_i};
            ld_q     <= {ld_q[FWD_STAGES-1:0], id_load_i};
            dst_q    <= {dst_q[FWD_STAGES-1:0], id_dst_i};
            ex_src_q <= issue ? id_src_i : '0;
            ex_use_q <= issue ? id_src_use_i : '0;
            if (stall_o && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: outputs get a default before the loops so no path leaves them unassigned (no latch).
    always_comb begin
        fwd_sel_o = '0;
        // Walk oldest to youngest so the youngest matching producer is written last and wins.
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = FWD_STAGES; j >= 1; j--) begin
                if (v_q[j] && we_q[j] && dst_q[j] == ex_src_q[k] &&
                    ex_src_q[k] != '0 && ex_use_q[k]) begin
                    fwd_sel_o[k*SEL_W +: SEL_W] = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        load_hit = '0;
        // Youngest writer decides: a younger non-load writer of the same register clears the hit.
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                if (v_q[j] && we_q[j] && dst_q[j] == id_src_i[k*AW +: AW] &&
                    id_src_i[k*AW +: AW] != '0 && id_src_use_i[k]) begin
                    load_hit[k] = ld_q[j] && (j + 1 < LOAD_STAGE);
                end
            end
        end
    end

    assign stall_o     = id_valid_i & ~flush_i & (|load_hit);
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random traffic on a default
// instance and a 3-source / 3-stage / load-stage-3 instance, both checked against a history model.
module tb_fwd_hazard_unit;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            id_valid;
    logic [2:0][4:0] src;
    logic [2:0]      use_v;
    logic [4:0]      id_dst;
    logic            id_we, id_load, flush;

    logic [3:0]      sel_a;
    logic            stall_a;
    logic [15:0]     cnt_a;
    logic [5:0]      sel_b;
    logic            stall_b;
    logic [15:0]     cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut_a (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid),
        .id_src_i     (src[1:0]),
        .id_src_use_i (use_v[1:0]),
        .id_dst_i     (id_dst),
        .id_we_i      (id_we),
        .id_load_i    (id_load),
        .flush_i      (flush),
        .fwd_sel_o    (sel_a),
        .stall_o      (stall_a),
        .stall_cnt_o  (cnt_a)
    );

    fwd_hazard_unit #(.AW(5), .NUM_SRC(3), .FWD_STAGES(3), .LOAD_STAGE(3)) dut_b (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid),
        .id_src_i     (src),
        .id_src_use_i (use_v),
        .id_dst_i     (id_dst),
        .id_we_i      (id_we),
        .id_load_i    (id_load),
        .flush_i      (flush),
        .fwd_sel_o    (sel_b),
        .stall_o      (stall_b),
        .stall_cnt_o  (cnt_b)
    );

    // Reference: list of instructions that entered EX, most recent first (index 0 = now in EX).
    typedef struct packed {
        logic            v;
        logic [4:0]      dst;
        logic            we;
        logic            ld;
        logic [2:0][4:0] src;
        logic [2:0]      use_m;
    } ins_t;

    ins_t hist_a[$];
    ins_t hist_b[$];
    int   exp_cnt_a, exp_cnt_b;

    function automatic ins_t hist_at(int which, int j);
        return (which == 0) ? hist_a[j] : hist_b[j];
    endfunction

    function automatic int exp_sel(int which, int k, int fs);
        ins_t ex = hist_at(which, 0);
        if (!ex.v || !ex.use_m[k] || ex.src[k] == 5'd0) return 0;
        for (int j = 1; j <= fs; j++) begin
            ins_t p = hist_at(which, j);
            if (p.v && p.we && p.dst == ex.src[k]) return j;
        end
        return 0;
    endfunction

    function automatic int exp_stall(int which, int nsrc, int fs, int ls);
        if (!id_valid || flush) return 0;
        for (int k = 0; k < nsrc; k++) begin
            if (use_v[k] && src[k] != 5'd0) begin
                for (int j = 0; j < fs; j++) begin
                    ins_t p = hist_at(which, j);
                    if (p.v && p.we && p.dst == src[k]) begin
                        if (p.ld && j + 1 < ls) return 1;
                        break;
                    end
                end
            end
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_a = {};
        hist_b = {};
        for (int i = 0; i < 3; i++) hist_a.push_front(ins_t'(0));
        for (int i = 0; i < 4; i++) hist_b.push_front(ins_t'(0));
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic we, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                         input logic fl);
        id_valid = v;
        id_dst   = d;
        id_we    = we;
        id_load  = ld;
        src      = '0;
        src[0]   = s0;
        src[1]   = s1;
        use_v    = {1'b0, u};
        flush    = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    endtask

    // Compare both instances against the model, advance one clock, then update the model.
    task automatic step();
        int   sa, sb;
        ins_t e;
        #1;
        sa = exp_stall(0, 2, 2, 2);
        sb = exp_stall(1, 3, 3, 3);
        check("a_stall", 32'(stall_a), 32'(sa));
        check("b_stall", 32'(stall_b), 32'(sb));
        for (int k = 0; k < 2; k++) check("a_sel", 32'(sel_a[k*2 +: 2]), 32'(exp_sel(0, k, 2)));
        for (int k = 0; k < 3; k++) check("b_sel", 32'(sel_b[k*2 +: 2]), 32'(exp_sel(1, k, 3)));
        check("a_cnt", 32'(cnt_a), 32'(exp_cnt_a));
        check("b_cnt", 32'(cnt_b), 32'(exp_cnt_b));
        @(posedge clk);
        e = '0;
        if (id_valid && !flush) begin
            e.v = 1'b1; e.dst = id_dst; e.we = id_we; e.ld = id_load;
            e.src = src; e.use_m = use_v;
        end
        hist_a.push_front((sa == 0) ? e : ins_t'(0));
        void'(hist_a.pop_back());
        hist_b.push_front((sb == 0) ? e : ins_t'(0));
        void'(hist_b.pop_back());
        if (sa != 0 && exp_cnt_a < 65535) exp_cnt_a++;
        if (sb != 0 && exp_cnt_b < 65535) exp_cnt_b++;
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b0;
        nop();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_sel_a", 32'(sel_a), 32'd0);
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        rst_i = 1'b1;

        // ALU back-to-back: add r3,r1,r2 ; sub r4,r3,r1
        drive(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0); step();
        drive(1, 5'd4, 1, 0, 5'd3, 5'd1, 2'b11, 0);
        #1 check("t1_stall", 32'(stall_a), 32'd0);
        step();
        nop();
        #1 check("t1_sel0", 32'(sel_a[1:0]), 32'd1);
        check("t1_sel1", 32'(sel_a[3:2]), 32'd0);
        step();

        // Priority: add r3 ; or r3 ; and r5,r3,r3 -> MEM wins
        drive(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0); step();
        drive(1, 5'd3, 1, 0, 5'd1, 5'd1, 2'b11, 0); step();
        drive(1, 5'd5, 1, 0, 5'd3, 5'd3, 2'b11, 0); step();
        nop();
        #1 check("t2_prio0", 32'(sel_a[1:0]), 32'd1);
        check("t2_prio1", 32'(sel_a[3:2]), 32'd1);
        step();
        // Distance 2: add r3 ; nop ; and r5,r3,r3 -> WB
        drive(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 0); step();
        nop(); step();
        drive(1, 5'd5, 1, 0, 5'd3, 5'd3, 2'b11, 0); step();
        nop();
        #1 check("t2_wb0", 32'(sel_a[1:0]), 32'd2);
        check("t2_wb1", 32'(sel_a[3:2]), 32'd2);
        step();

        // Load-use: lw r2 ; add r6,r2,r2
        drive(1, 5'd2, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd6, 1, 0, 5'd2, 5'd2, 2'b11, 0);
        #1 check("t3_stall_on", 32'(stall_a), 32'd1);
        step();
        #1 check("t3_stall_off", 32'(stall_a), 32'd0);
        check("t3_bubble", 32'(sel_a), 32'd0);
        step();
        nop();
        #1 check("t3_sel0", 32'(sel_a[1:0]), 32'd2);
        check("t3_sel1", 32'(sel_a[3:2]), 32'd2);
        check("t3_cnt", 32'(cnt_a), 32'd1);
        step();

        // Register 0 and unused sources
        drive(1, 5'd0, 1, 0, 5'd1, 5'd2, 2'b11, 0); step();
        drive(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b11, 0); step();
        nop();
        #1 check("t4_r0", 32'(sel_a), 32'd0);
        step();
        drive(1, 5'd2, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd6, 1, 0, 5'd2, 5'd2, 2'b00, 0);
        #1 check("t4_unused", 32'(stall_a), 32'd0);
        step();
        nop(); step(); step();

        // Flush wins over stall
        drive(1, 5'd2, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd6, 1, 0, 5'd2, 5'd2, 2'b11, 1);
        #1 check("t5_flush", 32'(stall_a), 32'd0);
        step();
        nop();
        #1 check("t5_flush_bub", 32'(sel_a), 32'd0);
        step(); step();
        // Shadowing: lw r2 ; add r2 ; use r2
        drive(1, 5'd2, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd2, 1, 0, 5'd1, 5'd1, 2'b11, 0); step();
        drive(1, 5'd8, 1, 0, 5'd2, 5'd0, 2'b01, 0);
        #1 check("t5_shadow", 32'(stall_a), 32'd0);
        step();
        nop();
        #1 check("t5_shadow_sel", 32'(sel_a[1:0]), 32'd1);
        step();

        // Random traffic on a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_dst   = 5'($urandom_range(0, 4));
            id_we    = ($urandom_range(0, 3) != 0);
            id_load  = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 3; k++) src[k] = 5'($urandom_range(0, 4));
            use_v    = 3'($urandom);
            flush    = ($urandom_range(0, 7) == 0);
            step();
        end
        nop(); step(); step(); step();

        // Reset in the middle of a stall
        drive(1, 5'd9, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd6, 1, 0, 5'd9, 5'd9, 2'b11, 0);
        #1 check("t6_pre_stall", 32'(stall_b), 32'd1);
        rst_i = 1'b0;
        #1 check("t6_rst_stall_a", 32'(stall_a), 32'd0);
        check("t6_rst_stall_b", 32'(stall_b), 32'd0);
        check("t6_rst_cnt_b", 32'(cnt_b), 32'd0);
        check("t6_rst_sel_b", 32'(sel_b), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        step();

        // Deep load stage: lw r9 ; dep -> two stalls, then WB-3 forward
        drive(1, 5'd9, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
        drive(1, 5'd6, 1, 0, 5'd9, 5'd9, 2'b11, 0);
        #1 check("t6_stall1", 32'(stall_b), 32'd1);
        step();
        #1 check("t6_stall2", 32'(stall_b), 32'd1);
        step();
        #1 check("t6_stall3", 32'(stall_b), 32'd0);
        step();
        nop();
        #1 check("t6_sel0", 32'(sel_b[1:0]), 32'd3);
        check("t6_sel1", 32'(sel_b[3:2]), 32'd3);
        check("t6_cnt", 32'(cnt_b), 32'd2);
        step();

        // Counter saturation: preload near the top, then stall past it
        force dut_b.stall_cnt_q = 16'hFFFD;
        @(posedge clk);
        @(negedge clk);
        release dut_b.stall_cnt_q;
        exp_cnt_b = 32'hFFFD;
        for (int r = 0; r < 2; r++) begin
            drive(1, 5'd9, 1, 1, 5'd1, 5'd0, 2'b01, 0); step();
            drive(1, 5'd6, 1, 0, 5'd9, 5'd9, 2'b11, 0); step(); step(); step();
        end
        nop();
        #1 check("t6_sat", 32'(cnt_b), 32'hFFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
